// File: rtl/wb_grf.sv
// wb_grf: MIPS write-back stage and 32x32 general register file.
// Builds write-back data, commits it, and serves D-stage reads with W->D bypass.
module wb_grf #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         IR_W,
    input  logic [31:0]         pc4_W,
    input  logic [31:0]         AO_W,
    input  logic [31:0]         DR_W,
    input  logic [4:0]          A1,
    input  logic [4:0]          A2,
    output logic [31:0]         RD1,
    output logic [31:0]         RD2,
    output logic [4:0]          WA_W,
    output logic [31:0]         WD_W,
    output logic                RegWrite_W,
    output logic [RETIRE_W-1:0] retired
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] link;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        wr_cls;
    logic [4:0]  dest;
    logic [31:0] sel_data;
    logic [31:0] rf [1:31];
    logic        unused_ir;

    assign op      = IR_W[31:26];
    assign funct   = IR_W[5:0];
    assign rt      = IR_W[20:16];
    assign rd      = IR_W[15:11];
    assign link    = pc4_W + 32'd4;
    assign ld_byte = DR_W[{AO_W[1:0], 3'b000} +: 8];
    assign ld_half = AO_W[1] ? DR_W[31:16] : DR_W[15:0];

    // rs and shamt never influence write-back
    assign unused_ir = ^{IR_W[25:21], IR_W[10:6]};

    // decode W-stage instruction into write class, destination and data
    always_comb begin
        wr_cls   = 1'b0;
        dest     = 5'd0;
        sel_data = 32'd0;
        case (op)
            6'b000000: begin
                wr_cls   = 1'b1;
                dest     = rd;
                sel_data = AO_W;
                case (funct)
                    6'b001000, 6'b011000, 6'b011001,
                    6'b011010, 6'b011011, 6'b010001,
                    6'b010011: wr_cls = 1'b0;
                    6'b001001: sel_data = link;
                    default: ;
                endcase
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                wr_cls   = 1'b1;
                dest     = rt;
                sel_data = AO_W;
            end
            6'b000011: begin
                wr_cls   = 1'b1;
                dest     = 5'd31;
                sel_data = link;
            end
            6'b100011: begin
                wr_cls   = 1'b1;
                dest     = rt;
                sel_data = DR_W;
            end
            6'b100000: begin
                wr_cls   = 1'b1;
                dest     = rt;
                sel_data = {{24{ld_byte[7]}}, ld_byte};
            end
            6'b100100: begin
                wr_cls   = 1'b1;
                dest     = rt;
                sel_data = {24'd0, ld_byte};
            end
            6'b100001: begin
                wr_cls   = 1'b1;
                dest     = rt;
                sel_data = {{16{ld_half[15]}}, ld_half};
            end
            6'b100101: begin
                wr_cls   = 1'b1;
                dest     = rt;
                sel_data = {16'd0, ld_half};
            end
            default: ;
        endcase
    end

    assign RegWrite_W = wr_cls && (dest != 5'd0);
    assign WA_W       = RegWrite_W ? dest : 5'd0;
    assign WD_W       = RegWrite_W ? sel_data : 32'd0;

    // register 0 is hardwired; same-cycle write is bypassed to readers
    assign RD1 = (A1 == 5'd0) ? 32'd0 :
                 (RegWrite_W && A1 == WA_W) ? WD_W : rf[A1];
    assign RD2 = (A2 == 5'd0) ? 32'd0 :
                 (RegWrite_W && A2 == WA_W) ? WD_W : rf[A2];

    // commit write-back data into the register array
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 1; i < 32; i++) rf[i] <= 32'd0;
        end else if (RegWrite_W) begin
            rf[WA_W] <= WD_W;
        end
    end

    // count every non-bubble instruction leaving the pipeline
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            retired <= '0;
        end else if (IR_W != 32'd0) begin
            retired <= retired + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed checks of wb_grf decode, extension, bypass,
// commit, reset and retire-counter wrap (4-bit counter instance).
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR_W, pc4_W, AO_W, DR_W;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2, WD_W;
    logic [4:0]  WA_W;
    logic        RegWrite_W;
    logic [3:0]  retired;

    int n_vec = 0;
    int n_bad = 0;

    wb_grf #(.RETIRE_W(4)) dut (
        .clk(clk), .clr(clr), .IR_W(IR_W), .pc4_W(pc4_W),
        .AO_W(AO_W), .DR_W(DR_W), .A1(A1), .A2(A2),
        .RD1(RD1), .RD2(RD2), .WA_W(WA_W), .WD_W(WD_W),
        .RegWrite_W(RegWrite_W), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc4,
                         input logic [31:0] ao, input logic [4:0] a1,
                         input logic [4:0] a2);
        @(negedge clk);
        IR_W  = ir;
        pc4_W = pc4;
        AO_W  = ao;
        A1    = a1;
        A2    = a2;
        #1;
    endtask

    initial begin
        clr = 1'b1;
        IR_W = 0; pc4_W = 0; AO_W = 0; DR_W = 0; A1 = 0; A2 = 0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rst_retired", 32'(retired), 32'd0);
        A1 = 5'd5;
        #1;
        chk("rst_rd5", RD1, 32'd0);

        // addu $5 <- 0x1234, then mid-cycle reset clears it
        drive(32'h0000_2821, 32'h0, 32'h1234, 5'd5, 5'd0);
        chk("addu_we", 32'(RegWrite_W), 32'd1);
        chk("addu_wa", 32'(WA_W), 32'd5);
        chk("addu_wd", WD_W, 32'h1234);
        drive(32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
        chk("addu_arr", RD1, 32'h1234);
        chk("addu_ret", 32'(retired), 32'd1);
        #1 clr = 1'b1;
        #1;
        chk("midrst_rd5", RD1, 32'd0);
        chk("midrst_ret", 32'(retired), 32'd0);
        #1 clr = 1'b0;

        // ori $8 with same-cycle bypass
        drive(32'h3508_00FF, 32'h0, 32'hFF, 5'd8, 5'd0);
        chk("ori_byp", RD1, 32'hFF);
        chk("ori_we", 32'(RegWrite_W), 32'd1);
        chk("ori_wa", 32'(WA_W), 32'd8);
        drive(32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
        chk("ori_arr", RD1, 32'hFF);
        chk("bub_we", 32'(RegWrite_W), 32'd0);
        chk("bub_wa", 32'(WA_W), 32'd0);
        chk("bub_wd", WD_W, 32'd0);
        chk("ori_ret", 32'(retired), 32'd1);
        drive(32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
        chk("bub_ret", 32'(retired), 32'd1);

        // load extension
        DR_W = 32'h80FF_7F01;
        drive(32'h8009_0000, 32'h0, 32'h1001, 5'd0, 5'd0);
        chk("lb1", WD_W, 32'h0000_007F);
        chk("lb1_wa", 32'(WA_W), 32'd9);
        drive(32'h800A_0000, 32'h0, 32'h1003, 5'd0, 5'd0);
        chk("lb3", WD_W, 32'hFFFF_FF80);
        drive(32'h900B_0000, 32'h0, 32'h1003, 5'd0, 5'd0);
        chk("lbu3", WD_W, 32'h0000_0080);
        drive(32'h840C_0000, 32'h0, 32'h1002, 5'd0, 5'd0);
        chk("lh2", WD_W, 32'hFFFF_80FF);
        drive(32'h940D_0000, 32'h0, 32'h1000, 5'd0, 5'd0);
        chk("lhu0", WD_W, 32'h0000_7F01);
        drive(32'h0, 32'h0, 32'h0, 5'd9, 5'd12);
        chk("lb_arr", RD1, 32'h0000_007F);
        chk("lh_arr", RD2, 32'hFFFF_80FF);
        chk("ld_ret", 32'(retired), 32'd6);

        // link writes
        drive(32'h0C00_0C00, 32'h3004, 32'h0, 5'd0, 5'd0);
        chk("jal_wa", 32'(WA_W), 32'd31);
        chk("jal_wd", WD_W, 32'h3008);
        drive(32'h03E0_2009, 32'h3010, 32'h0, 5'd4, 5'd4);
        chk("jalr_wa", 32'(WA_W), 32'd4);
        chk("byp_rd1", RD1, 32'h3014);
        chk("byp_rd2", RD2, 32'h3014);
        drive(32'h0, 32'h0, 32'h0, 5'd31, 5'd4);
        chk("jal_arr", RD1, 32'h3008);
        chk("jalr_arr", RD2, 32'h3014);

        // no-write classes
        drive(32'h0000_0021, 32'h0, 32'h5, 5'd0, 5'd0);
        chk("r0_we", 32'(RegWrite_W), 32'd0);
        chk("r0_wd", WD_W, 32'd0);
        chk("r0_rd", RD1, 32'd0);
        drive(32'hAC08_0000, 32'h0, 32'h8, 5'd8, 5'd0);
        chk("sw_we", 32'(RegWrite_W), 32'd0);
        chk("sw_ret", 32'(retired), 32'd9);
        drive(32'h1109_0003, 32'h0, 32'h1, 5'd9, 5'd0);
        chk("beq_we", 32'(RegWrite_W), 32'd0);
        chk("beq_ret", 32'(retired), 32'd10);
        drive(32'h03E0_0008, 32'h0, 32'hDEAD, 5'd31, 5'd0);
        chk("jr_we", 32'(RegWrite_W), 32'd0);
        chk("jr_rd", RD1, 32'h3008);
        drive(32'h0109_0018, 32'h0, 32'hBEEF, 5'd0, 5'd0);
        chk("mult_we", 32'(RegWrite_W), 32'd0);
        drive(32'h0, 32'h0, 32'h0, 5'd8, 5'd9);
        chk("keep8", RD1, 32'hFF);
        chk("keep9", RD2, 32'h7F);
        chk("nw_ret", 32'(retired), 32'd13);

        // reset coincident with a committing edge
        drive(32'h3508_0055, 32'h0, 32'h55, 5'd8, 5'd0);
        chk("edge_byp", RD1, 32'h55);
        #3 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        IR_W = 32'h0;
        #1;
        chk("edge_rd8", RD1, 32'd0);
        chk("edge_ret", 32'(retired), 32'd0);

        // counter wrap on the 16th commit
        for (int i = 0; i < 15; i++)
            drive(32'hAC08_0000, 32'h0, 32'h0, 5'd0, 5'd0);
        drive(32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        chk("wrap_15", 32'(retired), 32'd15);
        drive(32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        chk("wrap_bub", 32'(retired), 32'd15);
        drive(32'hAC08_0000, 32'h0, 32'h0, 5'd0, 5'd0);
        drive(32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        chk("wrap_0", 32'(retired), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
